// File: rtl/parking_lot_controller.sv
// parking_lot_controller: multi-gate parking-lot entry/exit arbiter with
// occupancy tracking, full/empty flags and a timed full-lot alarm.
// Optional macro PARK_STATS_EN adds saturating entries/denials counters.
module parking_lot_controller #(
  parameter  int CAPACITY     = 64,
  parameter  int NUM_GATES    = 2,
  parameter  int ALARM_CYCLES = 8,
  localparam int CNT_W        = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_GATES-1:0] req_valid,
  input  logic [NUM_GATES-1:0] req_entry,
  output logic [NUM_GATES-1:0] req_ready,
  output logic [NUM_GATES-1:0] req_deny,
  output logic [CNT_W-1:0]     occupancy,
  output logic                 lot_full,
  output logic                 lot_empty,
  output logic                 alarm,
  output logic [1:0]           state
`ifdef PARK_STATS_EN
  ,
  output logic [31:0]          entries_total,
  output logic [15:0]          denials_total
`endif
);

  localparam int PTR_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
  localparam int TMR_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CAP_C   = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_LD  = TMR_W'(ALARM_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ENTRY = 2'b01,
    S_EXIT  = 2'b10,
    S_ALARM = 2'b11
  } state_t;

  state_t               r_state, w_next;
  logic [CNT_W-1:0]     r_occ, w_occ;
  logic [PTR_W-1:0]     r_ptr, w_ptr;
  logic [TMR_W-1:0]     r_timer, w_timer;
  logic [NUM_GATES-1:0] r_ready, w_ready;
  logic [NUM_GATES-1:0] r_deny, w_deny;
  logic                 r_full, r_empty, r_alarm;
  logic [PTR_W:0]       w_pick_any, w_pick_exit;
  logic [PTR_W-1:0]     w_g_any, w_g_exit;

  // Round-robin search: first set bit of m at or after p, wrapping; MSB = found.
  function automatic logic [PTR_W:0] pick(input logic [NUM_GATES-1:0] m,
                                          input logic [PTR_W-1:0]     p);
    logic [PTR_W:0] res;
    int idx;
    res = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      idx = (int'(p) + i) % NUM_GATES;
      if (!res[PTR_W] && m[PTR_W'(idx)]) res = {1'b1, PTR_W'(idx)};
    end
    return res;
  endfunction

  // Pointer position just past gate g, wrapping to 0.
  function automatic logic [PTR_W-1:0] after(input logic [PTR_W-1:0] g);
    if (g == PTR_W'(NUM_GATES - 1)) return '0;
    return g + PTR_W'(1);
  endfunction

  // A gate being denied this cycle still shows valid until the next edge, so
  // it is masked out of the IDLE search to avoid a second deny.
  assign w_pick_any  = pick(req_valid & ~r_deny, r_ptr);
  assign w_pick_exit = pick(req_valid & ~req_entry, r_ptr);
  assign w_g_any     = w_pick_any[PTR_W-1:0];
  assign w_g_exit    = w_pick_exit[PTR_W-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state, arbitration and next-cycle handshake decisions.
  always_comb begin
    w_next  = r_state;
    w_occ   = r_occ;
    w_ptr   = r_ptr;
    w_timer = r_timer;
    w_ready = '0;
    w_deny  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_any[PTR_W]) begin
          w_ptr = after(w_g_any);
          if (req_entry[w_g_any]) begin
            if (r_occ < CAP_C) begin
              w_next           = S_ENTRY;
              w_occ            = r_occ + ONE_C;
              w_ready[w_g_any] = 1'b1;
            end else begin
              w_next          = S_ALARM;
              w_deny[w_g_any] = 1'b1;
              w_timer         = TMR_LD;
            end
          end else if (r_occ != '0) begin
            w_next           = S_EXIT;
            w_occ            = r_occ - ONE_C;
            w_ready[w_g_any] = 1'b1;
          end else begin
            w_deny[w_g_any] = 1'b1;
          end
        end
      end
      S_ENTRY, S_EXIT: w_next = S_IDLE;
      S_ALARM: begin
        if (w_pick_exit[PTR_W] && r_occ != '0) begin
          w_next            = S_EXIT;
          w_occ             = r_occ - ONE_C;
          w_ready[w_g_exit] = 1'b1;
          w_ptr             = after(w_g_exit);
        end else if (r_timer == '0) begin
          w_next = S_IDLE;
        end else begin
          w_timer = r_timer - TMR_W'(1);
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Registered occupancy, flags, handshake pulses, pointer and alarm timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ   <= '0;
      r_ptr   <= '0;
      r_timer <= '0;
      r_ready <= '0;
      r_deny  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_alarm <= 1'b0;
    end else begin
      r_occ   <= w_occ;
      r_ptr   <= w_ptr;
      r_timer <= w_timer;
      r_ready <= w_ready;
      r_deny  <= w_deny;
      r_full  <= (w_occ == CAP_C);
      r_empty <= (w_occ == '0);
      r_alarm <= (w_next == S_ALARM);
    end
  end

  assign req_ready = r_ready;
  assign req_deny  = r_deny;
  assign occupancy = r_occ;
  assign lot_full  = r_full;
  assign lot_empty = r_empty;
  assign alarm     = r_alarm;
  assign state     = r_state;

`ifdef PARK_STATS_EN
  logic [31:0] r_entries;
  logic [15:0] r_denials;

  // Saturating counters of entry grants and deny pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_entries <= '0;
      r_denials <= '0;
    end else begin
      if (w_next == S_ENTRY && r_entries != '1) r_entries <= r_entries + 32'd1;
      if (|w_deny && r_denials != '1)           r_denials <= r_denials + 16'd1;
    end
  end

  assign entries_total = r_entries;
  assign denials_total = r_denials;
`endif

endmodule
